sram_controller: RTL
====================

# sram_controller

Multi-cycle controller that sequences 32-bit word accesses from the MEM stage onto a 16-bit asynchronous external SRAM. It owns the `ready` signal that freezes the IF, ID, EXE and MEM stages while an access is in flight. It splits each word into two half-word SRAM cycles with programmable wait states. It returns assembled read data to the MEM/WB boundary.

## Interface
- `WAIT_CYCLES`, 5, cycles each half-word phase is held on the SRAM pins; minimum 1.
- `ADDR_W`, 18, SRAM half-word address width.
- `BASE_ADDR`, 1024, CPU byte address that maps to SRAM word 0.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rd_en`  in  1  read request from MEM stage; held until `ready`.
- `wr_en`  in  1  write request from MEM stage; held until `ready`.
- `address`  in  32  CPU byte address (word-aligned).
- `write_data`  in  32  store data.
- `read_data`  out  32  assembled load data.
- `ready`  out  1  access complete or no request pending; low freezes pipeline.
- `sram_addr`  out  ADDR_W  SRAM half-word address.
- `sram_dq_out`  out  16  write data to pad.
- `sram_dq_oe`  out  1  pad output enable.
- `sram_dq_in`  in  16  read data from pad.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  SRAM strobes, active-low.

## Operation
- States: IDLE, LO, HI, DONE. The wait counter is `$clog2(WAIT_CYCLES+1)` bits.
- IDLE:
  - When `wr_en` or `rd_en` is high, capture the address, data and operation, then go to LO.
  - If both are high, write wins.
- LO: half-word 0. Stays WAIT_CYCLES cycles, then goes to HI.
- HI: half-word 1. Stays WAIT_CYCLES cycles, then goes to DONE.
- DONE: one cycle, then IDLE.
- Address arithmetic:
  - `word = (address - BASE_ADDR) >> 2`, truncated to ADDR_W-1 bits.
  - `sram_addr = {word, 0}` in LO and `{word, 1}` in HI.
  - The low two address bits are ignored.
- Write:
  - `sram_dq_out` is `write_data[15:0]` in LO and `[31:16]` in HI.
  - `sram_dq_oe=1` and `sram_we_n=0` for the whole phase.
  - `sram_oe_n=1`.
- Read:
  - `sram_oe_n=0`, `sram_we_n=1`, `sram_dq_oe=0`.
  - `sram_dq_in` is latched into the low half on the last LO cycle and into the high half on the last HI cycle.
  - `read_data` holds its value until the next read completes.
- In LO and HI: `sram_ce_n=0`, `sram_ub_n=0`, `sram_lb_n=0`.
- Idle values (IDLE and DONE): all strobes 1, `sram_dq_oe=0`, `sram_addr=0`, `sram_dq_out=0`.
- `ready = (IDLE && !rd_en && !wr_en) || DONE` (combinational).
- A request dropped mid-access does not abort the access; `ready` stays low until DONE.
- A request held in DONE is treated as a new access starting in the following IDLE cycle. The MEM stage advances on `ready`.

## Timing
- Cycle 0 is the first IDLE cycle with a request.
  - LO covers cycles 1..W and HI covers W+1..2W.
  - DONE is cycle 2W+1, where `ready=1` and `read_data` is valid.
- `ready` is low on cycles 0..2W. Total 2W+2 cycles per blocking access.
- All SRAM outputs are registered and change only on `clk` edges.
- Reset values:
  - State IDLE, counter 0, `read_data=0`, strobes 1, `sram_dq_oe=0`, `sram_addr=0`, `sram_dq_out=0`.
  - `ready=1` while no request is present.
- Reset asserted mid-access forces idle values immediately; no partial write is retried.

## Configuration
- `SRAM_POSTED_WRITE_EN` defined:
  - A write in IDLE is captured and acknowledged with `ready=1` in cycle 0. It then runs LO/HI in the background and returns to IDLE, skipping DONE.
  - Any request arriving while the posted write is busy sees `ready=0` and starts in the first IDLE cycle afterwards.
- Not defined: writes block exactly like reads (2W+2 cycles, `ready` in DONE).

## Test plan
- W=5, write 0xDEADBEEF to 1028:
  - `sram_addr=2`, `dq_out=0xBEEF` on cycles 1-5.
  - `sram_addr=3`, `dq_out=0xDEAD` on cycles 6-10.
  - `we_n=0` throughout; `ready` high only on cycle 11.
- Read 1028 after the above, with the SRAM model returning the stored data: `oe_n=0` on cycles 1-10, `read_data=0xDEADBEEF` and `ready=1` on cycle 11.
- Read then write held back-to-back: `ready` pulses exactly one cycle per access, and the second access's LO starts 2 cycles after the first DONE.
- `rd_en` and `wr_en` both high: write performed, `read_data` unchanged.
- `rst` low on cycle 3 of a write: strobes go to 1 and `dq_oe` to 0 without waiting for a clock edge. After release, a read of 1024 completes normally with `sram_addr` 0 then 1.
- With `SRAM_POSTED_WRITE_EN`:
  - Write at cycle 0 gives `ready=1` on cycle 0.
  - Read presented on cycle 1 holds `ready=0` through cycle 21.
  - Read LO runs on cycles 12-16, and `ready=1` with valid data on cycle 22.

Source files
------------

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//
// Purpose:
//   Sequences 32-bit word accesses from the MEM stage onto a 16-bit
//   asynchronous SRAM. Each word is split into two half-word phases (LO, HI).
//   Each phase holds the SRAM pins for WAIT_CYCLES clock cycles.
//   While an access is in flight, 'ready' is low, which freezes the
//   IF/ID/EXE/MEM stages.
//
// Parameters:
//   WAIT_CYCLES  cycles each half-word phase is held on the pins (>= 1)
//   ADDR_W       SRAM half-word address width
//   BASE_ADDR    CPU byte address that maps to SRAM word 0
//
// Ports:
//   clk, rst                 clock (rising edge) and async active-low reset
//   rd_en, wr_en             MEM-stage requests, held until ready
//   address, write_data      CPU byte address and store data
//   read_data                assembled load data, held until next read ends
//   ready                    access complete or nothing pending
//   sram_addr                SRAM half-word address
//   sram_dq_out, sram_dq_oe  pad write data and pad output enable
//   sram_dq_in               pad read data
//   sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
//                            active-low SRAM strobes
//
// Configuration macro:
//   SRAM_POSTED_WRITE_EN  when defined, writes are acknowledged in the
//                         cycle they are accepted. They then complete in the
//                         background and skip DONE.
// ---------------------------------------------------------------------------
module sram_controller #(
    parameter int          WAIT_CYCLES = 5,
    parameter int          ADDR_W      = 18,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-2:0] word;
    logic [ADDR_W-2:0] word_next;
    logic [15:0]       wdata_hi;
    logic              is_write;

    // Word index relative to the SRAM base; the two byte-offset bits drop out
    // in the shift. The extra low bit of sram_addr selects the half-word.
    assign word_next = (ADDR_W-1)'((address - BASE_ADDR) >> 2);

`ifdef SRAM_POSTED_WRITE_EN
    // A write in IDLE is acknowledged immediately. Write takes priority, so a
    // simultaneous read is also released.
    assign ready = ((state == IDLE) && (wr_en || !rd_en)) || (state == DONE);
`else
    assign ready = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);
`endif

    // All pin outputs are registered. They are loaded on the edge that enters
    // a phase, so they hold steady for that whole phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            word        <= '0;
            wdata_hi    <= '0;
            is_write    <= 1'b0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        state       <= LO;
                        wait_cnt    <= '0;
                        word        <= word_next;
                        wdata_hi    <= write_data[31:16];
                        is_write    <= wr_en;
                        sram_addr   <= {word_next, 1'b0};
                        sram_dq_out <= wr_en ? write_data[15:0] : 16'h0000;
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= !wr_en;
                        sram_oe_n   <= wr_en;
                        sram_ce_n   <= 1'b0;
                        sram_ub_n   <= 1'b0;
                        sram_lb_n   <= 1'b0;
                    end
                end

                LO: begin
                    if (wait_cnt == LAST_CNT) begin
                        state     <= HI;
                        wait_cnt  <= '0;
                        sram_addr <= {word, 1'b1};
                        if (is_write) begin
                            sram_dq_out <= wdata_hi;
                        end else begin
                            read_data[15:0] <= sram_dq_in;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                HI: begin
                    if (wait_cnt == LAST_CNT) begin
`ifdef SRAM_POSTED_WRITE_EN
                        // Nobody waits on a posted write, so DONE is skipped.
                        state <= is_write ? IDLE : DONE;
`else
                        state <= DONE;
`endif
                        wait_cnt <= '0;
                        if (!is_write) begin
                            read_data[31:16] <= sram_dq_in;
                        end
                        sram_addr   <= '0;
                        sram_dq_out <= '0;
                        sram_dq_oe  <= 1'b0;
                        sram_ce_n   <= 1'b1;
                        sram_oe_n   <= 1'b1;
                        sram_we_n   <= 1'b1;
                        sram_ub_n   <= 1'b1;
                        sram_lb_n   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    // Pins are already idle here. A request that is still held
                    // gets picked up as a new access in the next IDLE cycle.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
